// File: rtl/processor_pkg.sv
// Shared pipeline-control types and limits.
package processor_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    DEBUG = 2'd2
  } state_t;

  localparam int unsigned STAGES_MAX    = 8;
  localparam int unsigned FLUSH_STAGE_W = 3;

endpackage

// File: rtl/stall_mask.sv
// Highest-set-bit hold request to per-stage advance vector: a hold at stage h
// stops stages 0..h, and every stage above h still advances.
module stall_mask #(
  parameter int unsigned STAGES = 3
) (
  input  logic [STAGES-1:0] hold_req,
  output logic [STAGES-1:0] advance
);

  always_comb begin
    advance = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      advance[k] = ~|(hold_req >> k);
    end
  end

endmodule

// File: rtl/pipeline_control.sv
// In-order pipeline control: stall/flush/wait sequencing, valid tracking and
// retire counting. Optional debug halt enabled by PROCESSOR_DEBUG_INTERFACE_EN.
module pipeline_control
  import processor_pkg::*;
#(
  parameter int unsigned STAGES     = 3,
  parameter int unsigned WAIT_STAGE = 1,
  parameter int unsigned CNT_WIDTH  = 18
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [STAGES-1:0]        stall_req,
  input  logic                     flush_req,
  input  logic [FLUSH_STAGE_W-1:0] flush_stage,
  input  logic                     wait_hit,
  input  logic                     wait_continue_execution,
`ifdef PROCESSOR_DEBUG_INTERFACE_EN
  input  logic                     debug_get_param,
`endif
  output logic                     wait_for_continue,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES-1:0]        stage_advance,
  output logic [CNT_WIDTH-1:0]     retire_count
);

  state_t            state;
  logic              dbg_active;
  logic              wait_stop;
  logic              wait_hold;
  logic              flush_eff;
  logic              wait_killed;
  logic [STAGES-1:0] wait_vec;
  logic [STAGES-1:0] kill_vec;
  logic [STAGES-1:0] mask_adv;
  logic [STAGES-1:0] valid_next;

`ifdef PROCESSOR_DEBUG_INTERFACE_EN
  state_t saved_state;
  assign dbg_active = debug_get_param || (state == DEBUG);
`else
  assign dbg_active = 1'b0;
`endif

  assign wait_stop   = (state == RUN) && wait_hit && !wait_continue_execution;
  assign wait_hold   = wait_stop || (state == WAIT);
  assign flush_eff   = flush_req && (32'(flush_stage) < STAGES);
  assign wait_killed = flush_eff && (32'(flush_stage) > WAIT_STAGE);

  // Wait holds and flush kills, expressed as per-stage vectors.
  always_comb begin
    wait_vec = '0;
    kill_vec = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      wait_vec[k] = wait_hold && (k <= WAIT_STAGE);
      kill_vec[k] = flush_eff && (k < 32'(flush_stage));
    end
  end

  stall_mask #(.STAGES(STAGES)) u_stall_mask (
    .hold_req (stall_req | wait_vec),
    .advance  (mask_adv)
  );

  assign stage_advance = (reset && !dbg_active) ? mask_adv : '0;

  // A stage that loads while its younger neighbour holds receives a bubble.
  always_comb begin
    valid_next    = stage_valid;
    valid_next[0] = stage_advance[0] ? 1'b1 : stage_valid[0];
    for (int unsigned k = 1; k < STAGES; k++) begin
      if (stage_advance[k]) begin
        valid_next[k] = stage_advance[k-1] && stage_valid[k-1];
      end
    end
    valid_next = valid_next & ~kill_vec;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stage_valid  <= '0;
      retire_count <= '0;
    end else if (!dbg_active) begin
      stage_valid <= valid_next;
      if (stage_valid[STAGES-1] && stage_advance[STAGES-1]) begin
        retire_count <= retire_count + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= RUN;
      wait_for_continue <= 1'b0;
`ifdef PROCESSOR_DEBUG_INTERFACE_EN
      saved_state       <= RUN;
`endif
    end
`ifdef PROCESSOR_DEBUG_INTERFACE_EN
    else if (dbg_active) begin
      if (state != DEBUG) begin
        saved_state <= state;
      end
      if (debug_get_param) begin
        state             <= DEBUG;
        wait_for_continue <= 1'b0;
      end else begin
        state             <= saved_state;
        wait_for_continue <= (saved_state == WAIT);
      end
    end
`endif
    else begin
      case (state)
        RUN: begin
          if (wait_stop && !wait_killed) begin
            state             <= WAIT;
            wait_for_continue <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_continue_execution || wait_killed) begin
            state             <= RUN;
            wait_for_continue <= 1'b0;
          end
        end
        default: begin
          state             <= RUN;
          wait_for_continue <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: reset, stall, flush, wait, counter wrap
// and (with PROCESSOR_DEBUG_INTERFACE_EN) debug halt.
module tb_pipeline_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] stall_req = '0;
  logic       flush_req = 1'b0;
  logic [2:0] flush_stage = '0;
  logic       wait_hit = 1'b0;
  logic       cont = 1'b0;
`ifdef PROCESSOR_DEBUG_INTERFACE_EN
  logic       dbg = 1'b0;
`endif
  logic       wfc;
  logic [2:0] valid;
  logic [2:0] adv;
  logic [17:0] cnt;

  logic       rst_w = 1'b0;
  logic       w_wfc;
  logic [2:0] w_valid;
  logic [2:0] w_adv;
  logic [3:0] w_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_control dut (
    .clock                   (clk),
    .reset                   (rst),
    .stall_req               (stall_req),
    .flush_req               (flush_req),
    .flush_stage             (flush_stage),
    .wait_hit                (wait_hit),
    .wait_continue_execution (cont),
`ifdef PROCESSOR_DEBUG_INTERFACE_EN
    .debug_get_param         (dbg),
`endif
    .wait_for_continue       (wfc),
    .stage_valid             (valid),
    .stage_advance           (adv),
    .retire_count            (cnt)
  );

  pipeline_control #(.CNT_WIDTH(4)) dut_w (
    .clock                   (clk),
    .reset                   (rst_w),
    .stall_req               (3'b000),
    .flush_req               (1'b0),
    .flush_stage             (3'b000),
    .wait_hit                (1'b0),
    .wait_continue_execution (1'b0),
`ifdef PROCESSOR_DEBUG_INTERFACE_EN
    .debug_get_param         (1'b0),
`endif
    .wait_for_continue       (w_wfc),
    .stage_valid             (w_valid),
    .stage_advance           (w_adv),
    .retire_count            (w_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held for two cycles
    tick(); tick();
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_cnt", 32'(cnt), 32'h0);
    chk("rst_wfc", 32'(wfc), 32'h0);
    chk("rst_adv", 32'(adv), 32'h0);
    rst = 1'b1;
    #1;
    chk("rel_valid", 32'(valid), 32'h0);
    chk("rel_adv", 32'(adv), 32'h7);
    tick(); chk("fill1", 32'(valid), 32'h1);
    tick(); chk("fill2", 32'(valid), 32'h3);
    tick(); chk("fill3", 32'(valid), 32'h7);
    chk("fill3_cnt", 32'(cnt), 32'h0);
    tick(); chk("first_retire", 32'(cnt), 32'h1);

    // Stall at stage 1 for one cycle
    stall_req = 3'b010;
    #1 chk("stall_adv", 32'(adv), 32'h4);
    tick();
    stall_req = 3'b000;
    chk("stall_bubble", 32'(valid), 32'h3);
    chk("stall_cnt", 32'(cnt), 32'h2);
    tick(); tick();
    chk("refill_valid", 32'(valid), 32'h7);
    chk("refill_cnt", 32'(cnt), 32'h3);

    // Flush from stage 2
    flush_req = 1'b1; flush_stage = 3'd2;
    #1 chk("flush_adv", 32'(adv), 32'h7);
    tick();
    flush_req = 1'b0;
    chk("flush_valid", 32'(valid), 32'h4);
    chk("flush_cnt", 32'(cnt), 32'h4);
    tick();
    chk("redirect_valid", 32'(valid), 32'h1);
    chk("redirect_cnt", 32'(cnt), 32'h5);

    // Out-of-range flush stage is ignored
    flush_req = 1'b1; flush_stage = 3'd3;
    tick();
    flush_req = 1'b0;
    chk("flush_oor_valid", 32'(valid), 32'h3);
    tick(); tick();
    chk("pre_wait_valid", 32'(valid), 32'h7);
    chk("pre_wait_cnt", 32'(cnt), 32'h6);

    // Wait entry, hold, and continue
    wait_hit = 1'b1; cont = 1'b0;
    #1 chk("wait_entry_adv", 32'(adv), 32'h4);
    chk("wait_entry_wfc", 32'(wfc), 32'h0);
    tick();
    chk("wait_wfc", 32'(wfc), 32'h1);
    chk("wait_valid", 32'(valid), 32'h3);
    chk("wait_cnt", 32'(cnt), 32'h7);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("wait_hold_wfc", 32'(wfc), 32'h1);
      chk("wait_hold_adv", 32'(adv), 32'h4);
    end
    chk("wait_hold_valid", 32'(valid), 32'h3);
    chk("wait_hold_cnt", 32'(cnt), 32'h7);
    wait_hit = 1'b0; cont = 1'b1;
    tick();
    cont = 1'b0;
    chk("cont_wfc", 32'(wfc), 32'h0);
    #1 chk("cont_adv", 32'(adv), 32'h7);
    tick();
    chk("cont_valid", 32'(valid), 32'h7);

    // Level-pass: wait with continue already high does not stop
    wait_hit = 1'b1; cont = 1'b1;
    #1 chk("pass_adv", 32'(adv), 32'h7);
    tick();
    wait_hit = 1'b0; cont = 1'b0;
    chk("pass_wfc", 32'(wfc), 32'h0);
    chk("pass_cnt", 32'(cnt), 32'h8);

    // Flush older than the wait stage releases WAIT
    wait_hit = 1'b1;
    tick();
    wait_hit = 1'b0;
    chk("wait2_wfc", 32'(wfc), 32'h1);
    chk("wait2_cnt", 32'(cnt), 32'h9);
    flush_req = 1'b1; flush_stage = 3'd2;
    tick();
    flush_req = 1'b0;
    chk("wflush_wfc", 32'(wfc), 32'h0);
    chk("wflush_valid", 32'(valid), 32'h0);
    chk("wflush_cnt", 32'(cnt), 32'h9);
    tick();
    chk("wflush_refetch", 32'(valid), 32'h1);

`ifdef PROCESSOR_DEBUG_INTERFACE_EN
    // Debug halt during WAIT
    tick(); tick(); tick();
    chk("dbg_pre_cnt", 32'(cnt), 32'ha);
    wait_hit = 1'b1;
    tick();
    wait_hit = 1'b0;
    chk("dbg_wait_wfc", 32'(wfc), 32'h1);
    dbg = 1'b1;
    #1 chk("dbg_adv", 32'(adv), 32'h0);
    tick();
    stall_req = 3'b111; flush_req = 1'b1; flush_stage = 3'd2; cont = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("dbg_valid", 32'(valid), 32'h3);
      chk("dbg_cnt", 32'(cnt), 32'hb);
      chk("dbg_wfc", 32'(wfc), 32'h0);
      chk("dbg_adv_hold", 32'(adv), 32'h0);
    end
    dbg = 1'b0; stall_req = 3'b000; flush_req = 1'b0; cont = 1'b0;
    #1 chk("dbg_exit_adv", 32'(adv), 32'h0);
    tick();
    chk("dbg_ret_wfc", 32'(wfc), 32'h1);
    chk("dbg_ret_valid", 32'(valid), 32'h3);
    chk("dbg_ret_cnt", 32'(cnt), 32'hb);
    cont = 1'b1;
    tick();
    cont = 1'b0;
    chk("dbg_run_wfc", 32'(wfc), 32'h0);
`endif

    // Retire counter wrap on the 4-bit instance
    rst_w = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    chk("wrap_15", 32'(w_cnt), 32'hf);
    tick();
    chk("wrap_16", 32'(w_cnt), 32'h0);
    tick();
    chk("wrap_17", 32'(w_cnt), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control.md
PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have parameter STAGES, default 3: pipeline depth; legal range 2..8; stage 0 is fetch, stage STAGES-1 is the oldest (writeback).
REQ-002 SHALL have parameter WAIT_STAGE, default 1: index of the stage that decodes wait; legal range 1..STAGES-1.
REQ-003 SHALL have parameter CNT_WIDTH, default 18: width of the retire counter.
REQ-004 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port stall_req, input, STAGES bits: bit k=1 means stage k cannot complete this cycle.
REQ-007 SHALL have port flush_req, input, 1 bit, and port flush_stage, input, 3 bits: the branch/call/return resolved in flush_stage kills all younger stages.
REQ-008 SHALL have port wait_hit, input, 1 bit: a valid wait instruction sits in WAIT_STAGE.
REQ-009 SHALL have port wait_continue_execution, input, 1 bit; port wait_for_continue, output, 1 bit.
REQ-010 SHALL have port stage_valid, output, STAGES bits, and port stage_advance, output, STAGES bits (load enable for each stage's pipeline register).
REQ-011 SHALL have port retire_count, output, CNT_WIDTH bits.

Function
REQ-012 SHALL implement states RUN, WAIT and (per REQ-025) DEBUG.
REQ-013 SHALL compute stage_advance combinationally: with h = highest k having stall_req[k]=1, stages 0..h SHALL NOT advance and stages h+1..STAGES-1 SHALL advance; with no stall, all stages SHALL advance.
REQ-014 SHALL insert a bubble: when stage h holds and stage h+1 advances, stage_valid[h+1] SHALL become 0 on the next edge.
REQ-015 SHALL set stage_valid[0]=1 every cycle in RUN in which stage 0 advances.
REQ-016 SHALL, on flush_req=1, clear stage_valid[0..flush_stage-1] on the next edge; stage flush_stage and older stages SHALL be unaffected; stage_valid[0] SHALL be 1 on the following edge (redirected fetch).
REQ-017 SHALL give flush priority over stall for stages younger than flush_stage; flush_stage>=STAGES SHALL be ignored.
REQ-018 SHALL, in RUN, with wait_hit=1 and wait_continue_execution=0, hold stages 0..WAIT_STAGE, drain older stages, and enter WAIT on the next edge.
REQ-019 SHALL not stop on wait_hit when wait_continue_execution=1 in the same cycle (level-pass).
REQ-020 SHALL drive wait_for_continue=1 exactly while in WAIT; in WAIT, stages 0..WAIT_STAGE hold.
REQ-021 SHALL, in WAIT, on wait_continue_execution=1 go to RUN on the next edge; the wait instruction SHALL advance in the first RUN cycle.
REQ-022 SHALL increment retire_count (modulo 2^CNT_WIDTH, wrapping to 0) each cycle stage_valid[STAGES-1]=1 and stage_advance[STAGES-1]=1.
REQ-023 SHALL apply flush in WAIT identically to RUN (a flush older than WAIT_STAGE that kills it also releases WAIT to RUN).

Reset
REQ-024 SHALL, on reset=0 asynchronously, set state RUN, stage_valid=0, retire_count=0, wait_for_continue=0; stage_advance SHALL be 0 while reset=0; reset mid-WAIT or mid-DEBUG SHALL abort to RUN.

Configuration
REQ-025 SHALL, with macro PROCESSOR_DEBUG_INTERFACE_EN defined, add port debug_get_param, input, 1 bit: while 1, enter DEBUG on the next edge; all stage_advance=0; stage_valid, retire_count and the saved RUN/WAIT state frozen; on return to 0, restore the saved state next edge; DEBUG dominates flush, stall and wait inputs.
REQ-026 SHALL, without PROCESSOR_DEBUG_INTERFACE_EN, omit debug_get_param and the DEBUG state entirely.

Structure
REQ-027 SHALL place the state enum (RUN, WAIT, DEBUG) and the STAGES upper limit constant in package processor_pkg.
REQ-028 SHALL implement the stall-priority mask in sub-module stall_mask (STAGES-bit highest-set-bit to advance vector).

Verification
REQ-029 SHALL verify reset: reset=0 for 2 cycles, release -> stage_valid 3'b000 then 3'b001, 3'b011, 3'b111; retire_count 1 on the cycle after that.
REQ-030 SHALL verify stall: stall_req=3'b010 for 1 cycle -> stage_advance=3'b100, next stage_valid[2]=0.
REQ-031 SHALL verify flush: flush_req=1, flush_stage=2, all valid -> next stage_valid=3'b100, then 3'b001.
REQ-032 SHALL verify wait: wait_hit=1, continue=0 -> WAIT, wait_for_continue=1 held 10 cycles; continue pulse -> RUN next edge; wait_hit with continue=1 -> no stop.
REQ-033 SHALL verify wrap: CNT_WIDTH=4, 17 retirements -> retire_count=1.
REQ-034 SHALL verify debug (macro on): debug_get_param=1 during WAIT -> all advance 0 and counters frozen; release -> returns to WAIT, wait_for_continue=1.
